// File: rtl/pgs_tsmac_gmii_rx_ctrl.sv
// rtl/pgs_tsmac_gmii_rx_ctrl.sv - GMII receive frame controller with RGMII in-band status decode
// Define RX_STAT_CNT_EN to build the saturating good/bad frame counters.
module pgs_tsmac_gmii_rx_ctrl #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        rx_en,
  input  logic        rx_dv_gm,
  input  logic        rx_er_gm,
  input  logic [7:0]  rxd_gm,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [13:0] frame_len,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        link_duplex,
  output logic [15:0] stat_good_cnt,
  output logic [15:0] stat_bad_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  localparam logic [13:0] MIN_LEN = 14'(MIN_FRAME);
  localparam logic [13:0] MAX_LEN = 14'(MAX_FRAME);
  localparam logic [13:0] LEN_SAT = '1;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic [13:0] len_q, len_d;
  logic [13:0] len_inc;
  logic        oversize;

  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        out_err_q, out_err_d;
  logic [13:0] frame_len_q, frame_len_d;

  logic [3:0]  nib_q, nib_d;
  logic        nib_vld_q, nib_vld_d;
  logic        link_up_q, link_up_d;
  logic [1:0]  link_speed_q, link_speed_d;
  logic        link_duplex_q, link_duplex_d;

  assign len_inc  = (len_q == LEN_SAT) ? len_q : len_q + 14'd1;
  // Byte MAX_FRAME+1 arriving while MAX_FRAME bytes are already counted.
  assign oversize = rx_dv_gm && (len_q == MAX_LEN);

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_dv_gm) state_d = (rx_en && rxd_gm == 8'h55) ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!rx_dv_gm)             state_d = S_IDLE;
        else if (rxd_gm == 8'hD5)  state_d = S_DATA;
        else if (rxd_gm != 8'h55)  state_d = S_DROP;
      end
      S_DATA: begin
        if (!rx_dv_gm)    state_d = S_IDLE;
        else if (oversize) state_d = S_DROP;
      end
      default: begin
        if (!rx_dv_gm) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    first_d       = first_q;
    err_d         = err_q;
    len_d         = len_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    out_sof_d     = 1'b0;
    out_eof_d     = 1'b0;
    out_err_d     = 1'b0;
    frame_len_d   = frame_len_q;
    nib_d         = nib_q;
    nib_vld_d     = 1'b0;
    link_up_d     = link_up_q;
    link_speed_d  = link_speed_q;
    link_duplex_d = link_duplex_q;
    case (state_q)
      S_IDLE: begin
        hold_vld_d = 1'b0;
        first_d    = 1'b1;
        err_d      = 1'b0;
        len_d      = '0;
        // In-band status only counts on clean gaps; false carrier breaks the debounce.
        if (!rx_dv_gm && !rx_er_gm) begin
          nib_d     = rxd_gm[3:0];
          nib_vld_d = 1'b1;
          if (nib_vld_q && nib_q == rxd_gm[3:0]) begin
            link_up_d     = rxd_gm[0];
            link_speed_d  = rxd_gm[2:1];
            link_duplex_d = rxd_gm[3];
          end
        end
      end
      S_DATA: begin
        if (rx_dv_gm) begin
          if (hold_vld_q) begin
            out_data_d  = hold_q;
            out_valid_d = 1'b1;
            out_sof_d   = first_q;
            first_d     = 1'b0;
          end
          if (oversize) begin
            out_eof_d   = 1'b1;
            out_err_d   = 1'b1;
            frame_len_d = len_q;
            hold_vld_d  = 1'b0;
          end else begin
            hold_d     = rxd_gm;
            hold_vld_d = 1'b1;
            len_d      = len_inc;
            err_d      = err_q | rx_er_gm;
          end
        end else begin
          if (hold_vld_q) begin
            out_data_d  = hold_q;
            out_valid_d = 1'b1;
            out_sof_d   = first_q;
            out_eof_d   = 1'b1;
            out_err_d   = err_q || (len_q < MIN_LEN) || (len_q > MAX_LEN);
            frame_len_d = len_q;
          end
          hold_vld_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      first_q       <= 1'b0;
      err_q         <= 1'b0;
      len_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      out_err_q     <= 1'b0;
      frame_len_q   <= '0;
      nib_q         <= '0;
      nib_vld_q     <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= '0;
      link_duplex_q <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      first_q       <= first_d;
      err_q         <= err_d;
      len_q         <= len_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
      out_eof_q     <= out_eof_d;
      out_err_q     <= out_err_d;
      frame_len_q   <= frame_len_d;
      nib_q         <= nib_d;
      nib_vld_q     <= nib_vld_d;
      link_up_q     <= link_up_d;
      link_speed_q  <= link_speed_d;
      link_duplex_q <= link_duplex_d;
    end
  end

`ifdef RX_STAT_CNT_EN
  logic [15:0] good_cnt_q, bad_cnt_q;

  // Counters step in the same cycle the eof byte appears on the outputs.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else if (out_eof_d) begin
      if (!out_err_d && good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
      if (out_err_d && bad_cnt_q != 16'hFFFF)   bad_cnt_q  <= bad_cnt_q + 16'd1;
    end
  end

  assign stat_good_cnt = good_cnt_q;
  assign stat_bad_cnt  = bad_cnt_q;
`else
  assign stat_good_cnt = 16'd0;
  assign stat_bad_cnt  = 16'd0;
`endif

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign out_err     = out_err_q;
  assign frame_len   = frame_len_q;
  assign link_up     = link_up_q;
  assign link_speed  = link_speed_q;
  assign link_duplex = link_duplex_q;

endmodule

// File: doc/pgs_tsmac_gmii_rx_ctrl.md
Name: pgs_tsmac_gmii_rx_ctrl

Overview:
Receive-side frame controller that sits directly behind the RGMII-to-GMII DDR capture stage, in the rx_clk domain.
- Qualifies GMII frames and strips preamble/SFD.
- Delimits payload with sof/eof and flags errored frames.
- Decodes RGMII in-band link status during inter-frame gaps.
- Keeps good/bad frame statistics for the MAC.

Parameters:
MIN_FRAME, 64, minimum legal length in bytes (after SFD, FCS included)
MAX_FRAME, 1518, maximum legal length in bytes; longer frames are truncated and flagged

Ports:
rx_clk  input  1  receive clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
rx_en  input  1  receive enable; sampled only in IDLE
rx_dv_gm  input  1  GMII data valid
rx_er_gm  input  1  GMII receive error
rxd_gm  input  8  GMII receive data
out_data  output  8  payload byte
out_valid  output  1  out_data valid strobe
out_sof  output  1  first payload byte (qualified by out_valid)
out_eof  output  1  last payload byte (qualified by out_valid)
out_err  output  1  frame error; valid with out_eof
frame_len  output  14  byte count of the frame; valid with out_eof
link_up  output  1  in-band link status
link_speed  output  2  00=10M, 01=100M, 10=1000M
link_duplex  output  1  1=full duplex
stat_good_cnt  output  16  good frame count, saturating
stat_bad_cnt  output  16  bad frame count, saturating

Behaviour:
- Reset (asynchronous): state IDLE; every output 0, including counters and link status; hold register empty; error flag clear.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_dv_gm=1, rx_en=1, rxd_gm=0x55 -> PREAMBLE.
  - rx_dv_gm=1, any other byte, or rx_en=0 -> DROP.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> DATA.
  - Any other byte -> DROP.
  - rx_dv_gm=0 -> IDLE. No output, no counter change.
- DATA:
  - Each byte sampled with rx_dv_gm=1 goes into a one-byte hold register and increments the length counter (14-bit, saturating).
  - The previously held byte is emitted as each new byte is sampled. out_* are registered.
  - A byte sampled at edge k appears on out_data in the cycle after edge k+1.
  - out_sof is set on the first emitted byte of the frame.
  - rx_er_gm=1 on any DATA cycle sets a sticky error flag.
- End of frame (rx_dv_gm falls in DATA):
  - The held byte is emitted with out_eof=1.
  - frame_len is the byte count.
  - out_err = sticky_err OR len<MIN_FRAME OR len>MAX_FRAME.
  - State -> IDLE.
- Oversize: when byte MAX_FRAME+1 is sampled, the held byte (byte MAX_FRAME) is emitted with out_eof=1, out_err=1, frame_len=MAX_FRAME. State -> DROP.
- 1-byte frame: a single byte is emitted with out_sof=out_eof=1 and out_err=1.
- DROP: ignore data; rx_dv_gm=0 -> IDLE. No output.
- Statistics: on each out_eof, stat_good_cnt increments if out_err=0, otherwise stat_bad_cnt increments. Both hold at 0xFFFF.
- In-band status:
  - Decoded in IDLE only, while rx_dv_gm=0 and rx_er_gm=0.
  - Fields: rxd_gm[0]=link, rxd_gm[2:1]=speed, rxd_gm[3]=duplex.
  - Outputs update only after the same nibble is seen on 2 consecutive qualifying cycles.
  - rx_dv_gm=0 with rx_er_gm=1 (false carrier/extension) is ignored and breaks the debounce.
- rx_en deasserted mid-frame: the frame in progress completes normally.
- Reset deasserted while rx_dv_gm=1 with non-preamble data: DROP until rx_dv_gm=0.
- No backpressure: the consumer must accept one byte per cycle.

Optional Feature:
RX_STAT_CNT_EN
- Defined: stat_good_cnt and stat_bad_cnt are implemented as described.
- Undefined: no counter logic is built; both ports are tied to 16'd0. All other behaviour is unchanged.

Test Plan:
- Frame of 7x0x55, 0xD5, 64 bytes 0x00..0x3F -> 64 out_valid pulses; out_sof on 0x00; out_eof on 0x3F; out_err=0; frame_len=64; stat_good_cnt=1.
- 20-byte frame after valid preamble -> out_eof with out_err=1, frame_len=20; stat_bad_cnt=1.
- rx_er_gm pulsed on byte 10 of a 100-byte frame -> all 100 bytes delivered; eof has out_err=1, frame_len=100.
- 1600-byte frame, MAX_FRAME=1518 -> out_eof on byte 1518 with out_err=1, frame_len=1518; no further out_valid until the next frame.
- Preamble 0x55,0x55,0x54, then data -> no out_valid; counters unchanged; next good frame is received correctly.
- IFG with rxd_gm=0x0D for 2 cycles -> link_up=1, link_speed=2'b10, link_duplex=1. A single-cycle 0x00 glitch leaves them unchanged. rst asserted mid-frame -> all outputs 0 immediately.
